// File: rtl/alu.sv
// 8-bit ALU with 19 opcodes and a registered result/carry.
// Define ALU_MULDIV_EN to build the multiplier and divider for opcodes 2, 3 and 16.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [4:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       ALU_Carry
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3,
    OP_SHL  = 5'd4,  OP_SHR  = 5'd5,  OP_ROL  = 5'd6,  OP_ROR  = 5'd7,
    OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_NOR  = 5'd11,
    OP_NAND = 5'd12, OP_XNOR = 5'd13, OP_GT   = 5'd14, OP_EQ   = 5'd15,
    OP_MOD  = 5'd16, OP_INC  = 5'd17, OP_DEC  = 5'd18
  } op_t;

  logic [8:0] sum;
  logic [7:0] result;
  logic       carry;

  assign sum = {1'b0, A} + {1'b0, B};

`ifdef ALU_MULDIV_EN
  logic [15:0] prod;
  assign prod = {8'h00, A} * {8'h00, B};
`endif

  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    case (ALU_Sel)
      OP_ADD:  begin result = sum[7:0]; carry = sum[8]; end
      OP_SUB:  begin result = A - B; carry = (A < B); end
`ifdef ALU_MULDIV_EN
      OP_MUL:  begin result = prod[7:0]; carry = |prod[15:8]; end
      // Divide by zero saturates to all-ones and raises the flag
      OP_DIV:  begin
        if (B == 8'h00) begin result = 8'hFF; carry = 1'b1; end
        else            result = A / B;
      end
      OP_MOD:  begin
        if (B == 8'h00) begin result = 8'hFF; carry = 1'b1; end
        else            result = A % B;
      end
`endif
      OP_SHL:  begin result = {A[6:0], 1'b0}; carry = A[7]; end
      OP_SHR:  begin result = {1'b0, A[7:1]}; carry = A[0]; end
      OP_ROL:  result = {A[6:0], A[7]};
      OP_ROR:  result = {A[0], A[7:1]};
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_NAND: result = ~(A & B);
      OP_XNOR: result = ~(A ^ B);
      OP_GT:   result = (A > B)  ? 8'h01 : 8'h00;
      OP_EQ:   result = (A == B) ? 8'h01 : 8'h00;
      OP_INC:  begin result = A + 8'd1; carry = (A == 8'hFF); end
      OP_DEC:  begin result = A - 8'd1; carry = (A == 8'h00); end
      default: begin result = 8'h00; carry = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_Out   <= 8'h00;
      ALU_Carry <= 1'b0;
    end else begin
      ALU_Out   <= result;
      ALU_Carry <= carry;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized traffic against an arithmetic reference model.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [4:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       ALU_Carry;

  int total_checks;
  int passed_checks;

  alu dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .ALU_Carry(ALU_Carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the opcode rules; returns {carry, result}
  function automatic logic [8:0] ref_model(input int op, input int a, input int b);
    int r;
    int c;
    logic [7:0] la;
    logic [7:0] lb;
    la = a[7:0];
    lb = b[7:0];
    r = 0;
    c = 0;
    case (op)
      0:  begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
      1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
`ifdef ALU_MULDIV_EN
      2:  begin r = (a * b) % 256; c = ((a * b) > 255) ? 1 : 0; end
      3:  begin if (b == 0) begin r = 255; c = 1; end else r = a / b; end
      16: begin if (b == 0) begin r = 255; c = 1; end else r = a % b; end
`endif
      4:  begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      5:  begin r = a / 2; c = a % 2; end
      6:  r = (a * 2) % 256 + a / 128;
      7:  r = a / 2 + (a % 2) * 128;
      8:  r = int'(la & lb);
      9:  r = int'(la | lb);
      10: r = int'(la ^ lb);
      11: r = 255 - int'(la | lb);
      12: r = 255 - int'(la & lb);
      13: r = 255 - int'(la ^ lb);
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      17: begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
      18: begin r = (a + 255) % 256; c = (a == 0) ? 1 : 0; end
      default: begin r = 0; c = 0; end
    endcase
    return {c[0], r[7:0]};
  endfunction

  // Present one operation, let one rising edge capture it, then settle past the edge
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
    A = a;
    B = b;
    ALU_Sel = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    A = 8'hC9; B = 8'hEC; ALU_Sel = 5'd0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_checks++;
      if (ALU_Out !== 8'h00 || ALU_Carry !== 1'b0)
        $display("[TB] FAIL reset_hold[%0d]: got %h/%b, expected 00/0", i, ALU_Out, ALU_Carry);
      else passed_checks++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total_checks++;
    if (ALU_Out !== 8'hB5 || ALU_Carry !== 1'b1)
      $display("[TB] FAIL reset_release: got %h/%b, expected b5/1", ALU_Out, ALU_Carry);
    else passed_checks++;
  endtask

  task automatic test_arith();
    logic [4:0] ops [4] = '{5'd0, 5'd1, 5'd17, 5'd18};
    logic [7:0] eo  [4] = '{8'hB5, 8'hDD, 8'hCA, 8'hC8};
    logic       ec  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(8'hC9, 8'hEC, ops[i]);
      total_checks++;
      if (ALU_Out !== eo[i] || ALU_Carry !== ec[i])
        $display("[TB] FAIL arith op%0d: got %h/%b, expected %h/%b", ops[i], ALU_Out, ALU_Carry, eo[i], ec[i]);
      else passed_checks++;
    end
  endtask

  task automatic test_logic();
    logic [4:0] ops [9] = '{5'd8, 5'd9, 5'd10, 5'd4, 5'd5, 5'd6, 5'd7, 5'd14, 5'd15};
    logic [7:0] eo  [9] = '{8'hC8, 8'hED, 8'h25, 8'h92, 8'h64, 8'h93, 8'hE4, 8'h00, 8'h00};
    logic       ec  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(8'hC9, 8'hEC, ops[i]);
      total_checks++;
      if (ALU_Out !== eo[i] || ALU_Carry !== ec[i])
        $display("[TB] FAIL logic op%0d: got %h/%b, expected %h/%b", ops[i], ALU_Out, ALU_Carry, eo[i], ec[i]);
      else passed_checks++;
    end
  endtask

  task automatic test_muldiv();
    logic [4:0] ops [4] = '{5'd2, 5'd3, 5'd16, 5'd3};
    logic [7:0] bs  [4] = '{8'hEC, 8'hEC, 8'hEC, 8'h00};
`ifdef ALU_MULDIV_EN
    logic [7:0] eo  [4] = '{8'h4C, 8'h00, 8'hC9, 8'hFF};
    logic       ec  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic [7:0] eo  [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic       ec  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(8'hC9, bs[i], ops[i]);
      total_checks++;
      if (ALU_Out !== eo[i] || ALU_Carry !== ec[i])
        $display("[TB] FAIL muldiv op%0d b=%h: got %h/%b, expected %h/%b", ops[i], bs[i], ALU_Out, ALU_Carry, eo[i], ec[i]);
      else passed_checks++;
    end
  endtask

  task automatic test_wrap_undef();
    logic [7:0] as  [4] = '{8'hFF, 8'h00, 8'h5A, 8'hFF};
    logic [4:0] ops [4] = '{5'd17, 5'd18, 5'd19, 5'd31};
    logic [7:0] eo  [4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    logic       ec  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(as[i], 8'h3C, ops[i]);
      total_checks++;
      if (ALU_Out !== eo[i] || ALU_Carry !== ec[i])
        $display("[TB] FAIL wrap_undef op%0d: got %h/%b, expected %h/%b", ops[i], ALU_Out, ALU_Carry, eo[i], ec[i]);
      else passed_checks++;
    end
  endtask

  // Consecutive opcodes 0..18 then back to 0, one per cycle with no idle gaps
  task automatic test_back_to_back();
    logic [8:0] exp_v;
    int a;
    int b;
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      exp_v = ref_model(i % 19, a, b);
      drive(a[7:0], b[7:0], 5'(i % 19));
      total_checks++;
      if (ALU_Out !== exp_v[7:0] || ALU_Carry !== exp_v[8])
        $display("[TB] FAIL sweep op%0d a=%h b=%h: got %h/%b, expected %h/%b",
                 i % 19, a[7:0], b[7:0], ALU_Out, ALU_Carry, exp_v[7:0], exp_v[8]);
      else passed_checks++;
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_v;
    int a;
    int b;
    int op;
    for (int i = 0; i < 300; i++) begin
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 31));
      exp_v = ref_model(op, a, b);
      drive(a[7:0], b[7:0], op[4:0]);
      total_checks++;
      if (ALU_Out !== exp_v[7:0] || ALU_Carry !== exp_v[8])
        $display("[TB] FAIL random op%0d a=%h b=%h: got %h/%b, expected %h/%b",
                 op, a[7:0], b[7:0], ALU_Out, ALU_Carry, exp_v[7:0], exp_v[8]);
      else passed_checks++;
    end
  endtask

  // Reset between edges clears outputs at once and discards the pending op
  task automatic test_reset_midstream();
    drive(8'hFF, 8'h01, 5'd0);
    A = 8'h10; B = 8'h20; ALU_Sel = 5'd9;
    #2;
    rst = 1'b1;
    #1;
    total_checks++;
    if (ALU_Out !== 8'h00 || ALU_Carry !== 1'b0)
      $display("[TB] FAIL reset_async: got %h/%b, expected 00/0", ALU_Out, ALU_Carry);
    else passed_checks++;
    @(posedge clk);
    #1;
    total_checks++;
    if (ALU_Out !== 8'h00 || ALU_Carry !== 1'b0)
      $display("[TB] FAIL reset_discard: got %h/%b, expected 00/0", ALU_Out, ALU_Carry);
    else passed_checks++;
    A = 8'h80; B = 8'h80; ALU_Sel = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total_checks++;
    if (ALU_Out !== 8'h00 || ALU_Carry !== 1'b1)
      $display("[TB] FAIL reset_first_result: got %h/%b, expected 00/1", ALU_Out, ALU_Carry);
    else passed_checks++;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst = 1'b0;
    A = 8'h00; B = 8'h00; ALU_Sel = 5'd0;
    test_reset();
    test_arith();
    test_logic();
    test_muldiv();
    test_wrap_undef();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
